uart_avm_sequencer: RTL and testbench
=====================================

# uart_avm_sequencer

Avalon-MM master sequencer that owns the UART peripheral's register port on behalf of the LED cube driver. It polls the UART status register and drains received bytes into a 4-entry receive FIFO. It also accepts transmit bytes from the driver and writes them when the UART reports TRDY. Received and transmitted traffic share the single master port through an alternating arbiter. It sits between the UART slave and the cube driver, replacing ad-hoc blind reads of rxdata.

## Interface
- POLL_DIV, 16: IDLE dwell in cycles between status polls; legal range is 1 or more.
- TIMEOUT, 64: cycles allowed from read acceptance to readdatavalid.
- ADDR_RXDATA, 0: rxdata register address.
- ADDR_TXDATA, 1: txdata register address.
- ADDR_STATUS, 2: status register address.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- avm_address  out  5  Avalon address.
- avm_read  out  1  Avalon read strobe.
- avm_write  out  1  Avalon write strobe.
- avm_writedata  out  16  {8'h00, tx byte}.
- avm_readdata  in  16  Avalon read data.
- avm_readdatavalid  in  1  read data qualifier.
- avm_waitrequest  in  1  slave stall.
- rx_data  out  8  FIFO head byte.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops the head byte when rx_valid and rx_ready are both high.
- tx_data  in  8  byte to send.
- tx_valid  in  1  transmit request.
- tx_ready  out  1  tx holding buffer empty.
- fifo_level  out  3  receive FIFO occupancy, 0..4.
- timeout_err  out  1  sticky flag, set on a readdatavalid timeout.
- clr_err  in  1  synchronous clear of timeout_err.

## Operation
- Status register bits: bit 7 is RRDY, bit 6 is TRDY.
- States: IDLE, ST_RD, ST_WAIT, DECIDE, RX_RD, RX_WAIT, TX_WR.
- IDLE
  - Poll counter counts 0..POLL_DIV-1, then moves to ST_RD.
  - The counter clears on every entry to IDLE.
- ST_RD: avm_read=1, avm_address=ADDR_STATUS; held until waitrequest=0, then ST_WAIT.
- ST_WAIT: on readdatavalid, latch RRDY and TRDY, then DECIDE.
- DECIDE
  - rx_ok = RRDY and fifo_level<4.
  - tx_ok = TRDY and the tx buffer is full.
  - Both true: grant the side opposite last_grant.
  - Only one true: grant that side.
  - Neither true: go to IDLE.
  - An rx grant goes to RX_RD; a tx grant goes to TX_WR.
  - last_grant updates on every grant.
- RX_RD: read at ADDR_RXDATA, held while waitrequest, then RX_WAIT.
- RX_WAIT: on readdatavalid, push readdata[7:0] into the FIFO, then IDLE.
- TX_WR
  - avm_write=1, avm_address=ADDR_TXDATA; held while waitrequest.
  - On acceptance: clear the tx buffer, then IDLE.
- Read/write strobe, address and writedata stay constant while waitrequest=1.
- avm_read and avm_write are never high together.
- Timeout
  - A counter runs in ST_WAIT and RX_WAIT.
  - Reaching TIMEOUT without readdatavalid sets timeout_err and goes to IDLE; no FIFO push occurs.
  - A late readdatavalid arriving in any other state is ignored.
- tx buffer: one entry, loaded when tx_valid and tx_ready; tx_ready = buffer empty.
- FIFO
  - Depth 4, pointer width 2 bits plus a wrap bit.
  - A push and a pop in the same cycle are both honored; the level is unchanged.
  - A full FIFO is never pushed because DECIDE backpressures; RRDY data stays in the UART.
- clr_err and a new timeout in the same cycle: the set wins.

## Timing
- Reset (async assert) values
  - State IDLE; all counters 0.
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0.
  - rx_valid=0, fifo_level=0, tx_ready=1, timeout_err=0.
  - last_grant=tx, so rx wins the first tie.
- Reset asserted mid-transaction: strobes drop immediately; FIFO and tx buffer contents are discarded.
- Strobes and address decode combinationally from the registered state, and assert in the first cycle of ST_RD, RX_RD or TX_WR.
- Zero-wait status poll: IDLE(POLL_DIV) → ST_RD(1) → ST_WAIT(≥1) → DECIDE(1).
- rx byte visibility: the byte appears on rx_data/rx_valid the cycle after the rxdata readdatavalid.
- rx_data is the FIFO head and is valid whenever rx_valid=1.

## Test plan
- Status poll, RRDY=1, rxdata=0x5A, zero waitrequest, readdatavalid one cycle after read
  - Status read at address 2, then rxdata read at address 0.
  - rx_valid=1 with rx_data=0x5A; fifo_level=1.
- tx_data=0xC3 pulsed, TRDY=1, waitrequest held 3 cycles
  - Write at address 1 with writedata=0x00C3, held 4 cycles.
  - tx_ready returns to 1 after acceptance.
- RRDY and TRDY both set with a tx pending, on repeated polls
  - Grants alternate rx, tx, rx.
  - The first grant after reset is rx.
- rx_ready=0, RRDY always set, bytes 1..6 offered
  - fifo_level saturates at 4; no rxdata read while full.
  - Draining yields bytes 1,2,3,4 in order, then 5 and 6 are read.
- readdatavalid withheld for TIMEOUT cycles
  - timeout_err=1, state returns to IDLE, no push.
  - clr_err clears the flag.
- rst_n asserted during TX_WR with waitrequest=1: avm_write=0 at once; tx_ready=1; fifo_level=0.

Source files
------------

// File: rtl/uart_avm_sequencer.sv
// uart_avm_sequencer: Avalon-MM master that polls the UART status register,
// drains received bytes into a 4-entry FIFO and writes queued transmit bytes,
// alternating between rx and tx service when both are ready.
module uart_avm_sequencer #(
    parameter int         POLL_DIV    = 16,
    parameter int         TIMEOUT     = 64,
    parameter logic [4:0] ADDR_RXDATA = 5'd0,
    parameter logic [4:0] ADDR_TXDATA = 5'd1,
    parameter logic [4:0] ADDR_STATUS = 5'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_waitrequest,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [2:0]  fifo_level,
    output logic        timeout_err,
    input  logic        clr_err
);
    typedef enum logic [2:0] {IDLE, ST_RD, ST_WAIT, DECIDE, RX_RD, RX_WAIT, TX_WR} state_t;

    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_poll_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            r_rrdy;
    logic            r_trdy;
    logic            r_last_tx;
    logic            r_timeout_err;
    logic            r_tx_full;
    logic [7:0]      r_tx_byte;
    logic [7:0]      r_fifo [4];
    logic [2:0]      r_wr_ptr;
    logic [2:0]      r_rd_ptr;

    logic [2:0]      w_level;
    logic            w_not_empty;
    logic            w_rx_ok;
    logic            w_tx_ok;
    logic            w_grant_rx;
    logic            w_grant_tx;
    logic            w_push;
    logic            w_pop;
    logic            w_timeout;
    logic            w_tx_load;
    logic            w_tx_done;
    logic            w_unused;

    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_not_empty = (w_level != 3'd0);
    assign w_rx_ok     = r_rrdy && (w_level < 3'd4);
    assign w_tx_ok     = r_trdy && r_tx_full;
    assign w_pop       = w_not_empty && rx_ready;
    assign w_tx_load   = tx_valid && !r_tx_full;
    assign w_unused    = &{1'b0, avm_readdata[15:8]};

    assign rx_data     = r_fifo[r_rd_ptr[1:0]];
    assign rx_valid    = w_not_empty;
    assign fifo_level  = w_level;
    assign tx_ready    = !r_tx_full;
    assign timeout_err = r_timeout_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic, bus strobes decoded from the registered state, and grant/push/timeout events.
    always_comb begin
        w_next        = r_state;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = 5'd0;
        avm_writedata = 16'h0000;
        w_grant_rx    = 1'b0;
        w_grant_tx    = 1'b0;
        w_push        = 1'b0;
        w_timeout     = 1'b0;
        w_tx_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_poll_cnt == POLL_LAST) w_next = ST_RD;
            end
            ST_RD: begin
                avm_read    = 1'b1;
                avm_address = ADDR_STATUS;
                if (!avm_waitrequest) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (avm_readdatavalid) begin
                    w_next = DECIDE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            DECIDE: begin
                // On a tie the side not served last time wins.
                if (w_rx_ok && w_tx_ok) begin
                    w_grant_rx = r_last_tx;
                    w_grant_tx = !r_last_tx;
                end else begin
                    w_grant_rx = w_rx_ok;
                    w_grant_tx = w_tx_ok;
                end
                if (w_grant_rx)      w_next = RX_RD;
                else if (w_grant_tx) w_next = TX_WR;
                else                 w_next = IDLE;
            end
            RX_RD: begin
                avm_read    = 1'b1;
                avm_address = ADDR_RXDATA;
                if (!avm_waitrequest) w_next = RX_WAIT;
            end
            RX_WAIT: begin
                if (avm_readdatavalid) begin
                    w_push = 1'b1;
                    w_next = IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            TX_WR: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_TXDATA;
                avm_writedata = {8'h00, r_tx_byte};
                if (!avm_waitrequest) begin
                    w_tx_done = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Poll dwell counter: advances only while staying in IDLE, so it is zero on every IDLE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_poll_cnt <= '0;
        else if (r_state == IDLE && w_next == IDLE)   r_poll_cnt <= r_poll_cnt + 1'b1;
        else                                          r_poll_cnt <= '0;
    end

    // Readdatavalid timeout counter, running only while waiting in ST_WAIT or RX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if ((r_state == ST_WAIT || r_state == RX_WAIT) && w_next == r_state)
            r_to_cnt <= r_to_cnt + 1'b1;
        else
            r_to_cnt <= '0;
    end

    // Status flag capture, arbitration history and sticky timeout flag (a new timeout beats clr_err).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrdy        <= 1'b0;
            r_trdy        <= 1'b0;
            r_last_tx     <= 1'b1;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT && avm_readdatavalid) begin
                r_rrdy <= avm_readdata[7];
                r_trdy <= avm_readdata[6];
            end
            if (w_grant_rx)      r_last_tx <= 1'b0;
            else if (w_grant_tx) r_last_tx <= 1'b1;
            if (w_timeout)       r_timeout_err <= 1'b1;
            else if (clr_err)    r_timeout_err <= 1'b0;
        end
    end

    // Transmit holding buffer occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_tx_full <= 1'b0;
        else if (w_tx_load) r_tx_full <= 1'b1;
        else if (w_tx_done) r_tx_full <= 1'b0;
    end

    // Transmit byte storage; contents are meaningless while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_tx_load) r_tx_byte <= tx_data;
    end

    // Receive FIFO pointers with wrap bit; simultaneous push and pop both advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
        end
    end

    // Receive FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[1:0]] <= avm_readdata[7:0];
    end
endmodule

// File: tb/tb_uart_avm_sequencer.sv
// Scoreboard bench for uart_avm_sequencer: a reactive UART slave model,
// queues of expected data-bus transactions and received bytes, and monitors
// that pop and compare whenever the DUT presents an accepted transfer or a byte.
module tb_uart_avm_sequencer;
    localparam int T_OUT = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = 16'h0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [2:0]  fifo_level;
    logic        timeout_err;
    logic        clr_err = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int last_wr_cyc = 0;

    logic [21:0] exp_bus [$];
    logic [7:0]  exp_rx  [$];

    logic [7:0]  sl_rxq [$];
    logic        sl_trdy = 1'b0;
    int          sl_wait_cfg = 0;
    logic        sl_hold_rx = 1'b0;

    uart_avm_sequencer #(.POLL_DIV(4), .TIMEOUT(T_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [21:0] bus_rd(input logic [4:0] a);
        return {1'b0, a, 16'h0000};
    endfunction

    function automatic logic [21:0] bus_wr(input logic [4:0] a, input logic [15:0] d);
        return {1'b1, a, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input logic [2:0] lv, input int maxc);
        int i = 0;
        while (fifo_level !== lv && i < maxc) begin tick(1); i++; end
        chk("wait_fifo_level", {29'd0, fifo_level}, {29'd0, lv});
    endtask

    task automatic wait_txready(input int maxc);
        int i = 0;
        while (tx_ready !== 1'b1 && i < maxc) begin tick(1); i++; end
        chk("wait_tx_ready", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic wait_bus(input int maxc);
        int i = 0;
        while (exp_bus.size() != 0 && i < maxc) begin tick(1); i++; end
        chk("bus_drained", exp_bus.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; clr_err = 1'b0;
        sl_trdy = 1'b0; sl_wait_cfg = 0; sl_hold_rx = 1'b0; sl_rxq.delete();
        #1;
        chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
        chk("rst_avm_write", {31'd0, avm_write}, 32'd0);
        chk("rst_avm_address", {27'd0, avm_address}, 32'd0);
        chk("rst_avm_writedata", {16'd0, avm_writedata}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        tick(2);
        rst_n = 1'b1;
    endtask

    // UART slave model: waitrequest per transfer, readdatavalid one cycle after read acceptance.
    initial begin
        int left = 0;
        logic in_txn = 1'b0;
        logic pend = 1'b0;
        logic [15:0] pend_d = 16'h0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (!rst_n) begin
                avm_waitrequest = 1'b0; in_txn = 1'b0; pend = 1'b0;
                continue;
            end
            if (pend) begin
                avm_readdatavalid = 1'b1; avm_readdata = pend_d; pend = 1'b0;
            end
            if (avm_read || avm_write) begin
                if (!in_txn) begin in_txn = 1'b1; left = sl_wait_cfg; end
                if (left > 0) begin
                    avm_waitrequest = 1'b1; left--;
                end else begin
                    avm_waitrequest = 1'b0; in_txn = 1'b0;
                    if (avm_read && avm_address == 5'd2) begin
                        pend_d = {8'h00, sl_rxq.size() != 0, sl_trdy, 6'h00};
                        pend = 1'b1;
                    end else if (avm_read && avm_address == 5'd0) begin
                        pend_d = {8'h00, (sl_rxq.size() != 0) ? sl_rxq.pop_front() : 8'hEE};
                        pend = !sl_hold_rx;
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    // Bus monitor: hold-while-stalled, status-before-data, and expected data transfers.
    initial begin
        logic [22:0] prev_v = '0;
        logic [22:0] cur_v;
        logic [21:0] cmp;
        logic prev_stall = 1'b0;
        logic prev_status = 1'b0;
        int wr_cyc = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                prev_stall = 1'b0; prev_status = 1'b0; wr_cyc = 0;
                continue;
            end
            cur_v = {avm_read, avm_write, avm_address, avm_writedata};
            if (prev_stall) chk("hold_while_stalled", {9'd0, cur_v}, {9'd0, prev_v});
            if (avm_write) wr_cyc++;
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                chk("rd_wr_exclusive", {31'd0, avm_read & avm_write}, 32'd0);
                if (avm_read && avm_address == 5'd2) begin
                    prev_status = 1'b1;
                end else begin
                    chk("status_before_data", {31'd0, prev_status}, 32'd1);
                    prev_status = 1'b0;
                    cmp = avm_write ? {1'b1, avm_address, avm_writedata} : {1'b0, avm_address, 16'h0000};
                    last_acc_cyc = cyc + 1;
                    if (avm_write) last_wr_cyc = wr_cyc;
                    if (exp_bus.size() == 0) begin
                        n_chk++;
                        $display("FAIL bus_unexpected: got 0x%0h expected none", cmp);
                    end else begin
                        chk("bus_xfer", {10'd0, cmp}, {10'd0, exp_bus.pop_front()});
                    end
                end
                wr_cyc = 0;
            end
            prev_stall = (avm_read || avm_write) && avm_waitrequest;
            prev_v = cur_v;
        end
    end

    // Receive monitor: every byte consumed must match the next expected byte.
    initial forever begin
        @(negedge clk); #1;
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_rx.size() == 0) begin
                n_chk++;
                $display("FAIL rx_unexpected: got 0x%0h expected none", rx_data);
            end else begin
                chk("rx_byte", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
    end

    initial begin
        int guard;
        tick(1);
        do_reset();

        // Single received byte 0x5A.
        sl_rxq.push_back(8'h5A);
        exp_bus.push_back(bus_rd(5'd0));
        wait_level(3'd1, 200);
        chk("rx_valid_after_rd", {31'd0, rx_valid}, 32'd1);
        chk("rx_data_5A", {24'd0, rx_data}, 32'h5A);
        exp_rx.push_back(8'h5A);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("level_after_pop", {29'd0, fifo_level}, 32'd0);
        wait_bus(10);

        // Transmit 0xC3 against 3 waitrequest cycles.
        sl_trdy = 1'b1; sl_wait_cfg = 3;
        exp_bus.push_back(bus_wr(5'd1, 16'h00C3));
        tx_data = 8'hC3; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("tx_ready_loaded", {31'd0, tx_ready}, 32'd0);
        wait_txready(300);
        chk("tx_write_cycles", last_wr_cyc, 32'd4);
        wait_bus(10);

        // Arbitration: rx first after reset, then alternating on ties.
        do_reset();
        sl_rxq.push_back(8'h11); sl_rxq.push_back(8'h22);
        sl_trdy = 1'b1; rx_ready = 1'b1;
        exp_bus.push_back(bus_rd(5'd0));
        exp_bus.push_back(bus_wr(5'd1, 16'h0077));
        exp_bus.push_back(bus_rd(5'd0));
        exp_bus.push_back(bus_wr(5'd1, 16'h0078));
        exp_rx.push_back(8'h11); exp_rx.push_back(8'h22);
        tx_data = 8'h77; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        wait_txready(300);
        tx_data = 8'h78; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        wait_bus(300);
        tick(3);
        chk("arb_rx_drained", exp_rx.size(), 32'd0);

        // FIFO saturation with the consumer stalled.
        do_reset();
        for (int b = 1; b <= 6; b++) sl_rxq.push_back(8'(b));
        for (int k = 0; k < 4; k++) exp_bus.push_back(bus_rd(5'd0));
        wait_level(3'd4, 400);
        tick(40);
        chk("level_saturated", {29'd0, fifo_level}, 32'd4);
        chk("no_read_while_full", sl_rxq.size(), 32'd2);
        exp_bus.push_back(bus_rd(5'd0)); exp_bus.push_back(bus_rd(5'd0));
        for (int b = 1; b <= 6; b++) exp_rx.push_back(8'(b));
        rx_ready = 1'b1;
        wait_bus(300);
        tick(5);
        chk("drain_all_bytes", exp_rx.size(), 32'd0);
        chk("level_empty", {29'd0, fifo_level}, 32'd0);

        // Readdatavalid withheld on an rxdata read.
        sl_hold_rx = 1'b1;
        sl_rxq.push_back(8'h99);
        exp_bus.push_back(bus_rd(5'd0));
        guard = 0;
        while (timeout_err !== 1'b1 && guard < 300) begin tick(1); guard++; end
        chk("timeout_set", {31'd0, timeout_err}, 32'd1);
        chk("timeout_latency", cyc - last_acc_cyc, T_OUT);
        chk("timeout_no_push", {29'd0, fifo_level}, 32'd0);
        sl_hold_rx = 1'b0;
        sl_rxq.push_back(8'h42);
        exp_bus.push_back(bus_rd(5'd0));
        exp_rx.push_back(8'h42);
        wait_bus(300);
        tick(3);
        chk("resume_after_timeout", exp_rx.size(), 32'd0);
        chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("timeout_cleared", {31'd0, timeout_err}, 32'd0);

        // Reset while a write is stalled.
        do_reset();
        sl_rxq.push_back(8'h33);
        exp_bus.push_back(bus_rd(5'd0));
        wait_level(3'd1, 200);
        sl_trdy = 1'b1; sl_wait_cfg = 50;
        tx_data = 8'h5F; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        guard = 0;
        while (avm_write !== 1'b1 && guard < 400) begin tick(1); guard++; end
        chk("stalled_write_seen", {31'd0, avm_write}, 32'd1);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_avm_write", {31'd0, avm_write}, 32'd0);
        chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_fifo_level", {29'd0, fifo_level}, 32'd0);
        tick(1);
        do_reset();
        tick(2);
        chk("final_bus_queue", exp_bus.size(), 32'd0);
        chk("final_rx_queue", exp_rx.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
